// File: rtl/if_id_skid_reg_pkg.sv
// Shared definitions for the fetch-to-decode pipeline register: default widths,
// the NOP encoding and the skid-buffer state encoding.
package if_id_skid_reg_pkg;

  localparam int          ADDR_W_DEF   = 32;
  localparam int          INST_W_DEF   = 32;
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/if_id_skid_reg_pipe_skid_buf.sv
// Two-entry valid/ready skid buffer with a generic payload. The main slot drives
// the outputs; the skid slot absorbs the one entry accepted while stalled.
module pipe_skid_buf
  import if_id_skid_reg_pkg::*;
#(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic [W-1:0] clear_val,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  skid_state_e  state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         ready_q, ready_d;
  logic         valid_q, valid_d;
  logic         in_fire, out_fire;

  assign in_fire   = in_valid & ready_q;
  assign out_fire  = valid_q & out_ready;
  assign in_ready  = ready_q;
  assign out_valid = valid_q;
  assign out_data  = main_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d = FULL;
          main_d  = in_data;
        end
      end
      FULL: begin
        if (in_fire && out_fire) begin
          main_d = in_data;
        end else if (in_fire) begin
          state_d = SKID;
          skid_d  = in_data;
        end else if (out_fire) begin
          state_d = EMPTY;
          main_d  = clear_val;
        end
      end
      SKID: begin
        if (out_fire) begin
          state_d = FULL;
          main_d  = skid_q;
        end
      end
      default: begin
        state_d = EMPTY;
        main_d  = clear_val;
      end
    endcase
    // Reset and flush both drop every held and incoming entry.
    if (rst || flush) begin
      state_d = EMPTY;
      main_d  = clear_val;
    end
    ready_d = (state_d != SKID);
    valid_d = (state_d != EMPTY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
    main_q <= main_d;
    skid_q <= skid_d;
  end

endmodule

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register: packs PC and instruction into the skid buffer and
// presents NOP_INST with a zero PC whenever decode sees no valid entry.
module if_id_skid_reg
  import if_id_skid_reg_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                INST_W   = INST_W_DEF,
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(NOP_INST_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic [INST_W-1:0] if_inst,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst
);

  localparam int W = ADDR_W + INST_W;

  logic [W-1:0] in_data;
  logic [W-1:0] out_data;
  logic [W-1:0] clear_val;

  assign in_data   = {if_pc, if_inst};
  assign clear_val = {{ADDR_W{1'b0}}, NOP_INST};

  pipe_skid_buf #(
    .W(W)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .clear_val (clear_val),
    .in_valid  (if_valid),
    .in_ready  (if_ready),
    .in_data   (in_data),
    .out_valid (id_valid),
    .out_ready (id_ready),
    .out_data  (out_data)
  );

  // The main slot already holds the NOP payload when invalid, so outputs stay flop-driven.
  assign id_pc   = out_data[W-1:INST_W];
  assign id_inst = out_data[INST_W-1:0];

endmodule
